slow_access_ctl: RTL and testbench

Sequences the accelerator's drop to stock bus speed for accesses to slow Mac peripherals. The block qualifies each bus access against the per-device slow-enable bits and the timeout held by the settings register. It runs a request/acknowledge handshake with the clock switcher and holds the slow window open for a programmable number of timebase ticks after the last qualifying access. It sits between the address decoder / settings register and the clock-switch logic.

---
 rtl/slow_pkg.sv | 13 +
 rtl/slow_timer.sv | 39 +++
 rtl/slow_access_ctl.sv | 118 +++++++++++
 tb/tb_slow_access_ctl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/slow_pkg.sv
// Shared encodings and defaults for the slow-access controller.
package slow_pkg;

   // Default width of the timeout field and hold counter.
   localparam int unsigned TwDefault = 4;

   // Controller state encodings.
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StHold = 2'd2;
   localparam logic [1:0] StRel  = 2'd3;

endpackage

// File: rtl/slow_timer.sv
// Hold counter: loadable down counter that decrements on a tick strobe and
// saturates at zero.
module slow_timer
   import slow_pkg::*;
#(
   parameter int unsigned TW = TwDefault
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   input  logic          tick_i,
   output logic          zero_o
);

   logic [TW-1:0] count_q, count_d;

   // Next count: load has priority over a tick; never wrap below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - TW'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/slow_access_ctl.sv
// Slow-access controller: qualifies bus accesses against per-device slow
// enables, handshakes with the clock switcher and holds the slow window open
// for a programmable number of timebase ticks after the last slow access.
module slow_access_ctl
   import slow_pkg::*;
#(
   parameter int unsigned TW = TwDefault
) (
   input  logic          CLK,
   input  logic          nPOR,
   input  logic          BACT,
   input  logic          IACKCyc,
   input  logic          VIACS,
   input  logic          IWMCS,
   input  logic          SCCCS,
   input  logic          SCSICS,
   input  logic          SndCS,
   input  logic          SlowIACK,
   input  logic          SlowVIA,
   input  logic          SlowIWM,
   input  logic          SlowSCC,
   input  logic          SlowSCSI,
   input  logic          SlowSnd,
   input  logic          SlowClockGate,
   input  logic [TW-1:0] SlowTimeout,
   input  logic          Tick,
   input  logic          SlowAck,
   output logic          SlowReq,
   output logic          SlowActive,
   output logic          SlowWait,
   output logic          ClockGate
);

   logic [1:0] state_q, state_d;
   logic       slow_req_q, slow_req_d;
   logic       slow_active_q, slow_active_d;
   logic       clock_gate_q, clock_gate_d;
   logic       match;
   logic       tmr_load, tmr_tick, tmr_zero;

   // Access to a device whose slow enable is set.
   assign match = BACT && ((IACKCyc && SlowIACK) || (VIACS && SlowVIA) ||
                           (IWMCS && SlowIWM) || (SCCCS && SlowSCC) ||
                           (SCSICS && SlowSCSI) || (SndCS && SlowSnd));

   // Next-state logic and hold-counter control.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_tick = 1'b0;
      case (state_q)
         StIdle: begin
            if (match) state_d = StReq;
         end
         StReq: begin
            if (SlowAck) begin
               state_d  = StHold;
               tmr_load = 1'b1;
            end
         end
         StHold: begin
            // A slow access restarts the window; a tick at zero closes it.
            // A dropped SlowAck here is ignored: the request stays asserted.
            if (match) begin
               tmr_load = 1'b1;
            end else if (Tick) begin
               if (tmr_zero) state_d = StRel;
               else          tmr_tick = 1'b1;
            end
         end
         StRel: begin
            // Wait for the switcher to finish releasing before re-requesting.
            if (!SlowAck) state_d = match ? StReq : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Registered outputs derived from the next state.
   always_comb begin
      slow_req_d    = (state_d == StReq) || (state_d == StHold);
      slow_active_d = (state_d == StHold);
      clock_gate_d  = SlowClockGate && slow_active_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         state_q       <= StIdle;
         slow_req_q    <= 1'b0;
         slow_active_q <= 1'b0;
         clock_gate_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         slow_req_q    <= slow_req_d;
         slow_active_q <= slow_active_d;
         clock_gate_q  <= clock_gate_d;
      end
   end

   slow_timer #(
      .TW (TW)
   ) u_timer (
      .clk_i      (CLK),
      .rst_ni     (nPOR),
      .load_i     (tmr_load),
      .load_val_i (SlowTimeout),
      .tick_i     (tmr_tick),
      .zero_o     (tmr_zero)
   );

   assign SlowReq    = slow_req_q;
   assign SlowActive = slow_active_q;
   assign ClockGate  = clock_gate_q;
   // Stall the access until the slow window is established.
   assign SlowWait   = match && !slow_active_q;

endmodule

// File: tb/tb_slow_access_ctl.sv
// Bench for slow_access_ctl: match-qualification vector table plus
// hand-written handshake/hold/release sequences, checked via a scoreboard.
module tb_slow_access_ctl;
   import slow_pkg::*;

   localparam int unsigned TW = 4;

   logic          CLK = 1'b0;
   logic          nPOR, BACT, SlowClockGate, Tick, SlowAck;
   logic [5:0]    sel, en;  // 0 IACK, 1 VIA, 2 IWM, 3 SCC, 4 SCSI, 5 Snd
   logic [TW-1:0] SlowTimeout;
   logic          SlowReq, SlowActive, SlowWait, ClockGate;

   slow_access_ctl #(
      .TW (TW)
   ) dut (
      .CLK           (CLK),
      .nPOR          (nPOR),
      .BACT          (BACT),
      .IACKCyc       (sel[0]),
      .VIACS         (sel[1]),
      .IWMCS         (sel[2]),
      .SCCCS         (sel[3]),
      .SCSICS        (sel[4]),
      .SndCS         (sel[5]),
      .SlowIACK      (en[0]),
      .SlowVIA       (en[1]),
      .SlowIWM       (en[2]),
      .SlowSCC       (en[3]),
      .SlowSCSI      (en[4]),
      .SlowSnd       (en[5]),
      .SlowClockGate (SlowClockGate),
      .SlowTimeout   (SlowTimeout),
      .Tick          (Tick),
      .SlowAck       (SlowAck),
      .SlowReq       (SlowReq),
      .SlowActive    (SlowActive),
      .SlowWait      (SlowWait),
      .ClockGate     (ClockGate)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard entry: expected {SlowReq, SlowActive, ClockGate, SlowWait}.
   typedef struct {
      string      name;
      int         due;
      logic [3:0] exp;
   } sb_t;
   sb_t sb[$];
   sb_t e;

   typedef struct {
      string      name;
      logic       bact;
      logic [5:0] sel;
      logic [5:0] en;
      logic       m;
   } vec_t;
   vec_t vecs[8];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input string name, input int dly, input logic [3:0] exp);
      sb_t s;
      s.name = name;
      s.due  = cyc + dly;
      s.exp  = exp;
      sb.push_back(s);
   endtask

   task automatic chk_val(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare due scoreboard entries mid-cycle, away from the active edge.
   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         if (e.due != cyc ||
             {SlowReq, SlowActive, ClockGate, SlowWait} !== e.exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d req/act/gate/wait got %b expected %b (due %0d)",
                     e.name, cyc, {SlowReq, SlowActive, ClockGate, SlowWait}, e.exp, e.due);
         end
      end
   end

   initial begin
      vecs[0] = '{"via_en",      1'b1, 6'b000010, 6'b000010, 1'b1};
      vecs[1] = '{"scsi_dis",    1'b1, 6'b010000, 6'b101111, 1'b0};
      vecs[2] = '{"no_bact",     1'b0, 6'b111111, 6'b111111, 1'b0};
      vecs[3] = '{"iack_en",     1'b1, 6'b000001, 6'b000001, 1'b1};
      vecs[4] = '{"snd_en",      1'b1, 6'b100000, 6'b100000, 1'b1};
      vecs[5] = '{"scc_sel_iwm", 1'b1, 6'b001000, 6'b000100, 1'b0};
      vecs[6] = '{"all_sel_off", 1'b1, 6'b111111, 6'b000000, 1'b0};
      vecs[7] = '{"iwm_all_en",  1'b1, 6'b000100, 6'b111111, 1'b1};

      nPOR = 1'b0; BACT = 1'b0; sel = '0; en = '0;
      SlowClockGate = 1'b0; SlowTimeout = '0; Tick = 1'b0; SlowAck = 1'b0;

      // Reset: outputs cleared, SlowWait still follows Match.
      step();
      step();
      BACT = 1'b1; sel = 6'b000010; en = 6'b000010;
      push("rst_wait", 0, 4'b0001);
      chk_val("rst_count", int'(dut.u_timer.count_q), 0);
      chk_val("rst_state", int'(dut.state_q), int'(StIdle));
      step();
      push("rst_hold", 0, 4'b0001);
      step();

      // Match qualification from IDLE: SlowWait now, SlowReq next cycle.
      for (int i = 0; i < 8; i++) begin
         nPOR = 1'b0; BACT = 1'b0; sel = '0; en = '0; SlowAck = 1'b0;
         step();
         nPOR = 1'b1;
         BACT = vecs[i].bact; sel = vecs[i].sel; en = vecs[i].en;
         push({vecs[i].name, "_wait"}, 0, {1'b0, 1'b0, 1'b0, vecs[i].m});
         step();
         push({vecs[i].name, "_req"}, 0, {vecs[i].m, 1'b0, 1'b0, vecs[i].m});
         step();
      end

      // Handshake: VIA access, ack three cycles later, hold for 3 ticks.
      nPOR = 1'b0; BACT = 1'b0; sel = '0; en = '0; SlowAck = 1'b0;
      step();
      nPOR = 1'b1; SlowTimeout = 4'd3; SlowClockGate = 1'b1; en = 6'b000010;
      step();
      BACT = 1'b1; sel = 6'b000010;
      push("hs_match", 0, 4'b0001);
      step();
      push("hs_req1", 0, 4'b1001);
      step();
      push("hs_req2", 0, 4'b1001);
      step();
      SlowAck = 1'b1;
      push("hs_ack", 0, 4'b1001);
      step();
      push("hs_active", 0, 4'b1110);
      step();
      BACT = 1'b0; sel = '0;
      push("hs_idle_bus", 0, 4'b1110);
      chk_val("hs_loaded", int'(dut.u_timer.count_q), 3);
      for (int i = 0; i < 4; i++) begin
         step();
         Tick = 1'b1;
         push("hold_tick", 0, 4'b1110);
         step();
         Tick = 1'b0;
         if (i < 3) push("hold_gap", 0, 4'b1110);
         else       push("release", 0, 4'b0000);
         chk_val("hold_count", int'(dut.u_timer.count_q), (i < 3) ? (2 - i) : 0);
      end

      // REL with SlowAck still high: IWM access waits until ack drops.
      step();
      SlowTimeout = 4'd2;
      BACT = 1'b1; sel = 6'b000100; en = 6'b000110;
      push("rel_wait", 0, 4'b0001);
      step();
      push("rel_wait2", 0, 4'b0001);
      chk_val("rel_state", int'(dut.state_q), int'(StRel));
      step();
      SlowAck = 1'b0;
      push("rel_ack_low", 0, 4'b0001);
      step();
      push("rel_to_req", 0, 4'b1001);
      chk_val("req_state", int'(dut.state_q), int'(StReq));
      SlowAck = 1'b1;
      step();
      push("req_to_hold", 0, 4'b1110);
      step();
      BACT = 1'b0; sel = '0;
      push("hold2", 0, 4'b1110);
      chk_val("hold2_count", int'(dut.u_timer.count_q), 2);
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      push("hold2_tick", 0, 4'b1110);
      chk_val("count_one", int'(dut.u_timer.count_q), 1);

      // Tick and SCC access together at count 1: reload wins.
      SlowTimeout = 4'd7; Tick = 1'b1; BACT = 1'b1; sel = 6'b001000; en = 6'b001110;
      push("tick_match", 0, 4'b1110);
      step();
      Tick = 1'b0; BACT = 1'b0; sel = '0;
      push("reload_no_release", 0, 4'b1110);
      chk_val("reload_count", int'(dut.u_timer.count_q), 7);
      Tick = 1'b1;
      step();
      SlowClockGate = 1'b0;
      push("gate_still_on", 0, 4'b1110);
      step();
      Tick = 1'b0;
      push("gate_off", 0, 4'b1100);
      chk_val("count_five", int'(dut.u_timer.count_q), 5);

      // Reset from HOLD with count 5.
      nPOR = 1'b0;
      step();
      nPOR = 1'b1;
      push("rst_in_hold", 0, 4'b0000);
      chk_val("rst_hold_count", int'(dut.u_timer.count_q), 0);
      chk_val("rst_hold_state", int'(dut.state_q), int'(StIdle));
      step();
      step();

      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
